// File: rtl/fifo_reader.sv
// Read-side controller for a show-ahead FIFO: a 2-entry skid buffer feeding a valid/ready consumer.
// Optional accepted-word counter enabled by defining FIFO_READER_CNT_EN.
module fifo_reader #(
    parameter int BW   = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_enable,
    input  logic            flush,
    input  logic            fifo_empty,
    input  logic [BW-1:0]   fifo_data_out,
    output logic            fifo_rd,
    output logic            out_valid,
    output logic [BW-1:0]   out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic [CNTW-1:0] word_count
);

    // The state encoding doubles as the skid-buffer occupancy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [BW-1:0] entry_reg  [2];
    logic [BW-1:0] entry_next [2];
    logic          pop;

    always_comb begin
        fifo_rd   = ~reset & rd_enable & ~flush & ~fifo_empty & (state_reg != FULL);
        out_valid = ~reset & ~flush & (state_reg != IDLE);
        pop       = out_valid & out_ready;
        busy      = ~reset & ((state_reg != IDLE) | fifo_rd);
        out_data  = entry_reg[0];
    end

    always_comb begin
        state_next    = state_reg;
        entry_next[0] = entry_reg[0];
        entry_next[1] = entry_reg[1];
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fifo_rd) begin
                        state_next    = RUN;
                        entry_next[0] = fifo_data_out;
                    end
                end
                RUN: begin
                    // A simultaneous read and pop replaces the head and keeps one word buffered.
                    if (fifo_rd && pop) begin
                        entry_next[0] = fifo_data_out;
                    end else if (fifo_rd) begin
                        state_next    = FULL;
                        entry_next[1] = fifo_data_out;
                    end else if (pop) begin
                        state_next = IDLE;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next    = RUN;
                        entry_next[0] = entry_reg[1];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
        end else begin
            state_reg    <= state_next;
            entry_reg[0] <= entry_next[0];
            entry_reg[1] <= entry_next[1];
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [CNTW-1:0] count_reg;

    // Saturating count of accepted words; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (pop && (count_reg != {CNTW{1'b1}})) begin
            count_reg <= count_reg + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign word_count = count_reg;
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural FIFO plus a queue model of the words in flight.
module tb_fifo_reader;

    localparam int BW   = 4;
    localparam int CNTW = 8;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            rd_enable;
    logic            flush;
    logic            fifo_empty;
    logic [BW-1:0]   fifo_data_out;
    logic            fifo_rd;
    logic            out_valid;
    logic [BW-1:0]   out_data;
    logic            out_ready;
    logic            busy;
    logic [CNTW-1:0] word_count;

    fifo_reader #(.BW(BW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_enable    (rd_enable),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd      (fifo_rd),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model.
    logic [BW-1:0] fifo_mem [1024];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          rd_pending = 1'b0;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_data_out = fifo_rd ? fifo_mem[rd_ptr[9:0]] : '0;

    always @(posedge clk) begin
        if (rd_pending) rd_ptr <= rd_ptr + 1;
    end

    // Scoreboard state.
    logic [BW-1:0] exp_q [$];
    int            checks      = 0;
    int            failures    = 0;
    int            total_reads = 0;
    int            model_count = 0;
    bit            reset_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: sampled mid-cycle, after inputs and combinational outputs settle.
    always @(negedge clk) begin
        logic          exp_rd;
        logic          exp_valid;
        logic [BW-1:0] w;
        rd_pending = fifo_rd && !fifo_empty;
        if (fifo_rd) total_reads++;
        if (fifo_rd && fifo_empty) begin
            checks++;
            failures++;
            $display("FAIL underrun actual=1 required=0 t=%0t", $time);
        end
        if (reset) begin
            check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            if (reset_seen) begin
                check("rst_out_data", {28'd0, out_data}, 32'd0);
                check("rst_word_count", {24'd0, word_count}, 32'd0);
            end
            exp_q.delete();
            model_count = 0;
            reset_seen  = 1;
        end else begin
            reset_seen = 0;
            exp_rd    = rd_enable && !flush && !fifo_empty && (exp_q.size() < 2);
            exp_valid = !flush && (exp_q.size() != 0);
            check("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            check("busy", {31'd0, busy}, {31'd0, (exp_q.size() != 0) || exp_rd});
`ifdef FIFO_READER_CNT_EN
            check("word_count", {24'd0, word_count}, model_count);
`else
            check("word_count", {24'd0, word_count}, 32'd0);
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    w = exp_q.pop_front();
                    check("out_data", {28'd0, out_data}, {28'd0, w});
                    if (model_count < CMAX) model_count++;
                    $display("pop data=%h accepted=%0d", out_data, model_count);
                end
                if (exp_rd) exp_q.push_back(fifo_mem[rd_ptr[9:0]]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [BW-1:0] w);
        fifo_mem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(fifo_empty && exp_q.size() == 0 && !out_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required<%0d", n, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;
        // Reset held with a non-empty FIFO and reads enabled.
        reset = 1; rd_enable = 1; flush = 0; out_ready = 1;
        push_word(4'h1); push_word(4'h2); push_word(4'h3);
        step(); step();
        check("rst_out_data_direct", {28'd0, out_data}, 32'd0);
        reset = 0;
        // Back-to-back streaming of 0x1..0x3.
        wait_drain(20);

        // Back-pressure: only two words may be taken, head stays 0x1.
        out_ready = 0;
        r0 = total_reads;
        push_word(4'h1); push_word(4'h2); push_word(4'h3); push_word(4'h4);
        repeat (6) step();
        check("bp_reads", total_reads - r0, 32'd2);
        check("bp_head", {28'd0, out_data}, 32'd1);
        out_ready = 1;
        wait_drain(20);

        // Empty FIFO with reads enabled: no strobe at all.
        r0 = total_reads;
        repeat (20) step();
        check("empty_reads", total_reads - r0, 32'd0);

        // Flush while full with 0x5,0x6; 0x7 must be the next word delivered.
        out_ready = 0;
        r0 = total_reads;
        push_word(4'h5); push_word(4'h6); push_word(4'h7);
        n = 0;
        while (total_reads - r0 < 2 && n < 10) begin
            step();
            n++;
        end
        check("flush_prefill", total_reads - r0, 32'd2);
        flush = 1;
        step();
        flush = 0;
        out_ready = 1;
        wait_drain(20);
        check("flush_resume_reads", total_reads - r0, 32'd3);

        // Randomised traffic with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            rd_enable = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            reset     = (i == 200 || i == 201);
            if ($urandom_range(0, 1) == 1) push_word(BW'($urandom));
            step();
        end
        reset = 0; flush = 0; rd_enable = 1; out_ready = 1;
        wait_drain(1200);

        // Counter saturation after a fresh reset.
        reset = 1;
        step(); step();
        reset = 0;
        for (int i = 0; i < 300; i++) push_word(BW'(i));
        wait_drain(700);
`ifdef FIFO_READER_CNT_EN
        check("count_saturated", {24'd0, word_count}, CMAX);
`else
        check("count_disabled", {24'd0, word_count}, 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
